// File: rtl/fpaddsub_normround_pipe_pkg.sv
// Shared widths, field positions and stage bundles for the
// FP add/sub normalise-round pipeline.
package fpaddsub_normround_pipe_pkg;

    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS = 127;
    localparam int EXP_MAX = 255;

    localparam int SUM_W = 26;
    localparam int SUM_CARRY = 25;
    localparam int SUM_HIDDEN = 24;
    localparam int SUM_FRAC_HI = 23;
    localparam int SUM_FRAC_LO = 1;
    localparam int SUM_GUARD = 0;

    localparam int LZC_IN_W = SUM_HIDDEN + 1;
    localparam int LZC_W = 5;
    localparam int XEXP_W = EXP_W + 2;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF_IN,
        CLS_OVF,
        CLS_UNF
    } cls_t;

    typedef struct packed {
        logic             valid;
        logic [SUM_W-1:0] sum;
        logic             rnd;
        logic             stk;
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic [LZC_W-1:0] k;
        logic             zero;
    } s1_t;

    typedef struct packed {
        logic              valid;
        logic [FRAC_W-1:0] frac;
        logic              g;
        logic              r;
        logic              s;
        logic [XEXP_W-1:0] exp;
        logic              sign;
        logic              zero;
        logic              inf;
    } s2_t;

endpackage

// File: rtl/fpaddsub_normround_pipe_lzc.sv
// Leading-zero counter over the 25-bit hidden+fraction+guard field.
// count is 25 and zero is set when the input is all zeros.
module fpaddsub_lzc
    import fpaddsub_normround_pipe_pkg::*;
(
    input  logic [LZC_IN_W-1:0] in,
    output logic [LZC_W-1:0]    count,
    output logic                zero
);

    // Highest set bit wins: later loop iterations overwrite earlier ones.
    always_comb begin
        count = LZC_W'(LZC_IN_W);
        for (int i = 0; i < LZC_IN_W; i++) begin
            if (in[i]) count = LZC_W'(LZC_IN_W - 1 - i);
        end
        zero = ~|in;
    end

endmodule

// File: rtl/fpaddsub_normround_pipe.sv
// Three-stage normalise / round / pack back end for FP add/sub.
// Optional flag outputs enabled by defining FPADDSUB_FLAGS_EN.
module fpaddsub_normround_pipe
    import fpaddsub_normround_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             round_in,
    input  logic             sticky_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             sign_in,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FPADDSUB_FLAGS_EN
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inx,
`endif
    output logic [31:0]      result
);

    localparam logic signed [XEXP_W-1:0] EMAX_X = XEXP_W'(EXP_MAX);
    localparam logic signed [XEXP_W-1:0] ZERO_X = '0;

    logic en;
    assign en = ~out_valid | out_ready;
    assign in_ready = en;

    // S1: leading-zero detect on the incoming sum
    logic [LZC_W-1:0] lzc_k;
    logic             lzc_zero;

    fpaddsub_lzc u_lzc (
        .in    (sum_in[SUM_HIDDEN:0]),
        .count (lzc_k),
        .zero  (lzc_zero)
    );

    s1_t s1_d, s1_q;

    // Bundle S1 inputs together with the detected shift amount
    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sum   = sum_in;
        s1_d.rnd   = round_in;
        s1_d.stk   = sticky_in;
        s1_d.exp   = exp_in;
        s1_d.sign  = sign_in;
        s1_d.k     = lzc_k;
        s1_d.zero  = ~sum_in[SUM_CARRY] & lzc_zero;
    end

    // S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_q <= '0;
        else if (en) s1_q <= s1_d;
    end

    // S2: shift into place and adjust the exponent
    s2_t              s2_d, s2_q;
    logic [SUM_W-1:0] ext;

    // Normal case is just a zero-distance left shift of {sum, round}
    always_comb begin
        s2_d       = '0;
        ext        = {s1_q.sum[SUM_HIDDEN:0], s1_q.rnd} << s1_q.k;
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.zero  = s1_q.zero;
        s2_d.inf   = (s1_q.exp == EXP_W'(EXP_MAX));
        if (s1_q.sum[SUM_CARRY]) begin
            s2_d.frac = s1_q.sum[SUM_HIDDEN:SUM_FRAC_LO+1];
            s2_d.g    = s1_q.sum[SUM_FRAC_LO];
            s2_d.r    = s1_q.sum[SUM_GUARD];
            s2_d.s    = s1_q.rnd | s1_q.stk;
            s2_d.exp  = XEXP_W'(s1_q.exp) + XEXP_W'(1);
        end else begin
            s2_d.frac = ext[SUM_FRAC_HI+1:SUM_FRAC_LO+1];
            s2_d.g    = ext[SUM_FRAC_LO];
            s2_d.r    = ext[SUM_GUARD];
            s2_d.s    = s1_q.stk;
            s2_d.exp  = XEXP_W'(s1_q.exp) - XEXP_W'(s1_q.k);
        end
    end

    // S2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s2_q <= '0;
        else if (en) s2_q <= s2_d;
    end

    // S3: round to nearest even, classify and pack
    logic              inc;
    logic [FRAC_W:0]   fr;
    logic [FRAC_W-1:0] fo;
    logic [XEXP_W-1:0] ef;
    cls_t              cls;
    logic [31:0]       res_d;

    // Rounding carry-out clears the fraction and bumps the exponent
    always_comb begin
        inc = s2_q.g & (s2_q.r | s2_q.s | s2_q.frac[0]);
        fr  = {1'b0, s2_q.frac} + {{FRAC_W{1'b0}}, inc};
        ef  = s2_q.exp + {{(XEXP_W-1){1'b0}}, fr[FRAC_W]};
        fo  = fr[FRAC_W] ? '0 : fr[FRAC_W-1:0];
        if (s2_q.inf) cls = CLS_INF_IN;
        else if (s2_q.zero) cls = CLS_ZERO;
        else if ($signed(ef) >= EMAX_X) cls = CLS_OVF;
        else if ($signed(ef) <= ZERO_X) cls = CLS_UNF;
        else cls = CLS_NORM;
        unique case (cls)
            CLS_ZERO: res_d = '0;
            CLS_INF_IN,
            CLS_OVF: res_d = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            CLS_UNF: res_d = {s2_q.sign, {(EXP_W+FRAC_W){1'b0}}};
            default: res_d = {s2_q.sign, ef[EXP_W-1:0], fo};
        endcase
    end

    logic [31:0] result_q;
    logic        v3_q;

    // S3 register: output result and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q     <= 1'b0;
            result_q <= '0;
        end else if (en) begin
            v3_q     <= s2_q.valid;
            result_q <= res_d;
        end
    end

    assign out_valid = v3_q;
    assign result = result_q;

`ifdef FPADDSUB_FLAGS_EN
    logic ovf_d, unf_d, inx_d;
    logic ovf_q, unf_q, inx_q;

    // Overflow and underflow force inexact; passthrough infinity is exact
    always_comb begin
        ovf_d = (cls == CLS_OVF);
        unf_d = (cls == CLS_UNF);
        inx_d = ovf_d | unf_d |
                ((cls != CLS_INF_IN) & (s2_q.g | s2_q.r | s2_q.s));
    end

    // S3 flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
        end
    end

    assign flag_ovf = ovf_q;
    assign flag_unf = unf_q;
    assign flag_inx = inx_q;
`endif

endmodule

// File: tb/tb_fpaddsub_normround_pipe.sv
// Directed testbench for fpaddsub_normround_pipe.
// Flag checks are compiled in when FPADDSUB_FLAGS_EN is defined.
module tb_fpaddsub_normround_pipe;

    typedef struct {
        logic [25:0] sum;
        logic        rnd;
        logic        stk;
        logic [7:0]  exp;
        logic        sign;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] sum_in;
    logic        round_in;
    logic        sticky_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;

    int checks;
    int errors;

    fpaddsub_normround_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .round_in  (round_in),
        .sticky_in (sticky_in),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FPADDSUB_FLAGS_EN
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx),
`endif
        .result    (result)
    );

`ifndef FPADDSUB_FLAGS_EN
    assign flag_ovf = 1'b0;
    assign flag_unf = 1'b0;
    assign flag_inx = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [25:0] s, input logic r,
                                input logic t, input logic [7:0] e,
                                input logic sg, input logic [31:0] res,
                                input logic [2:0] f);
        vec_t v;
        v.sum = s; v.rnd = r; v.stk = t; v.exp = e;
        v.sign = sg; v.res = res; v.flg = f;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        sum_in = v.sum;
        round_in = v.rnd;
        sticky_in = v.stk;
        exp_in = v.exp;
        sign_in = v.sign;
    endtask

    task automatic apply(input vec_t v, input int n);
        string nm;
        nm = $sformatf("vec%0d", n);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        #1 chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk({nm, "_lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk({nm, "_lat3"}, 32'(out_valid), 32'd1);
        chk({nm, "_result"}, result, v.res);
`ifdef FPADDSUB_FLAGS_EN
        chk({nm, "_flags"}, {29'b0, flag_ovf, flag_unf, flag_inx},
            {29'b0, v.flg});
`endif
    endtask

    vec_t vec[18];
    int   idx[5];

    initial begin
        int sent, rcv, hold_pending, saw_low;
        logic acc_in;
        logic [31:0] held;

        checks = 0;
        errors = 0;
        clk = 0;
        rst_n = 0;
        in_valid = 0;
        out_ready = 1;
        sum_in = '0;
        round_in = 0;
        sticky_in = 0;
        exp_in = '0;
        sign_in = 0;

        vec[0]  = mk(26'h1000000, 0, 0, 8'd127, 0, 32'h3F800000, 3'b000);
        vec[1]  = mk(26'h2000000, 0, 0, 8'd127, 0, 32'h40000000, 3'b000);
        vec[2]  = mk(26'h0800000, 0, 0, 8'd127, 0, 32'h3F000000, 3'b000);
        vec[3]  = mk(26'h0000000, 0, 0, 8'd127, 0, 32'h00000000, 3'b000);
        vec[4]  = mk(26'h1FFFFFF, 0, 0, 8'd127, 0, 32'h40000000, 3'b001);
        vec[5]  = mk(26'h2000000, 0, 0, 8'd254, 0, 32'h7F800000, 3'b101);
        vec[6]  = mk(26'h0000002, 0, 0, 8'd5,   0, 32'h00000000, 3'b011);
        vec[7]  = mk(26'h1000000, 0, 0, 8'd127, 1, 32'hBF800000, 3'b000);
        vec[8]  = mk(26'h1000000, 0, 0, 8'd255, 1, 32'hFF800000, 3'b000);
        vec[9]  = mk(26'h1000001, 0, 0, 8'd127, 0, 32'h3F800000, 3'b001);
        vec[10] = mk(26'h1000001, 0, 1, 8'd127, 0, 32'h3F800001, 3'b001);
        vec[11] = mk(26'h2000003, 0, 0, 8'd127, 0, 32'h40000001, 3'b001);
        vec[12] = mk(26'h0800000, 1, 0, 8'd127, 0, 32'h3F000000, 3'b001);
        vec[13] = mk(26'h0000001, 0, 0, 8'd127, 0, 32'h33800000, 3'b000);
        vec[14] = mk(26'h2000000, 0, 0, 8'd253, 0, 32'h7F000000, 3'b000);
        vec[15] = mk(26'h0800000, 0, 0, 8'd2,   0, 32'h00800000, 3'b000);
        vec[16] = mk(26'h0800000, 0, 0, 8'd1,   1, 32'h80000000, 3'b011);
        vec[17] = mk(26'h1FFFFFF, 0, 0, 8'd254, 0, 32'h7F800000, 3'b101);

        idx[0] = 0; idx[1] = 2; idx[2] = 7; idx[3] = 13; idx[4] = 14;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 18; i++) apply(vec[i], i);

        @(negedge clk);
        drive(vec[1]);
        in_valid = 1;
        @(negedge clk);
        drive(vec[5]);
        @(negedge clk);
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        apply(vec[0], 100);

        repeat (4) @(posedge clk);
        sent = 0;
        rcv = 0;
        hold_pending = 0;
        saw_low = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && rcv < 5; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc < 8);
            in_valid = (sent < 5);
            if (sent < 5) drive(vec[idx[sent]]);
            #1;
            if (hold_pending != 0) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", result, held);
                hold_pending = 0;
            end
            if (!in_ready && saw_low == 0) begin
                saw_low = 1;
                chk("inflight_at_stall", 32'(sent), 32'd3);
            end
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d", rcv), result,
                    vec[idx[rcv]].res);
                rcv++;
            end
            if (out_valid && !out_ready) begin
                held = result;
                hold_pending = 1;
            end
            @(posedge clk);
            if (acc_in) sent++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_sent", 32'(sent), 32'd5);
        chk("stream_rcv", 32'(rcv), 32'd5);
        chk("stream_stalled", 32'(saw_low), 32'd1);

        repeat (5) @(posedge clk);
        #1 chk("drained", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fpaddsub_normround_pipe.md
FPADDSUB_NORMROUND_PIPE -- requirements
Module: fpaddsub_normround_pipe

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1, rst_n in 1.
REQ-002 SHALL have: in_valid  in  1  upstream execute-stage result valid.
REQ-003 SHALL have: in_ready  out  1  block accepts a transaction this cycle.
REQ-004 SHALL have: sum_in  in  26  raw significand sum; [25] carry, [24] hidden, [23:1] fraction, [0] guard.
REQ-005 SHALL have: round_in, sticky_in  in  1 each  round and sticky bits below the guard.
REQ-006 SHALL have: exp_in  in  8  biased exponent of the larger operand.
REQ-007 SHALL have: sign_in  in  1  result sign from the execute stage.
REQ-008 SHALL have: out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-009 SHALL have: result  out  32  IEEE-754 single-precision sum.
REQ-010 SHALL have, only with FPADDSUB_FLAGS_EN: flag_ovf, flag_unf, flag_inx  out  1 each.

Function
REQ-011 Transfer in SHALL occur when in_valid & in_ready; transfer out SHALL occur when out_valid & out_ready.
REQ-012 Pipeline SHALL be 3 stages: S1 normalise-detect (carry / leading-zero count over sum_in[24:0]), S2 shift and exponent adjust, S3 round-to-nearest-even and pack.
REQ-013 Global enable en = ~out_valid | out_ready; all stages SHALL advance only when en=1; in_ready SHALL equal en.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid with out_ready held high; throughput 1 per cycle.
REQ-015 While out_ready=0 and out_valid=1, result and flags SHALL hold stable; no transaction SHALL be dropped, duplicated or reordered.
REQ-016 Carry case (sum_in[25]=1): fraction = sum_in[24:2], G = sum_in[1], R = sum_in[0], S = round_in|sticky_in, exponent+1.
REQ-017 Normal case (sum_in[25:24]=01): fraction = sum_in[23:1], G = sum_in[0], R = round_in, S = sticky_in, exponent unchanged.
REQ-018 Cancellation case (sum_in[25:24]=00, nonzero): shift left by leading-zero count k (1..24), shifting in round_in then zeros; exponent-k; S = sticky_in.
REQ-019 sum_in, round_in and sticky_in all zero SHALL yield result 0x00000000 (+0).
REQ-020 Rounding SHALL increment fraction when G & (R | S | lsb); fraction overflow SHALL zero fraction and increment exponent.
REQ-021 Final exponent >= 255 SHALL yield signed infinity (exp 0xFF, fraction 0); flag_ovf=1, flag_inx=1.
REQ-022 Final exponent <= 0 SHALL flush to signed zero (no subnormals); flag_unf=1; flag_inx=1.
REQ-023 exp_in = 255 SHALL pass signed infinity through; NaN handling is upstream's responsibility.
REQ-024 flag_inx SHALL be G|R|S after normalisation, or forced per REQ-021/022.

Reset
REQ-025 On rst_n low, all stage valid bits, out_valid, result and flags SHALL clear to 0 asynchronously; in_ready SHALL read 1.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; first input after release SHALL appear 3 cycles later.

Configuration
REQ-027 FPADDSUB_FLAGS_EN defined: flag ports and their pipeline registers present per REQ-021/022/024.
REQ-028 FPADDSUB_FLAGS_EN undefined: flag ports and registers absent; result behaviour identical.

Structure
REQ-029 Shared package SHALL hold: exponent/fraction widths (8, 23), bias 127, EXP_MAX 255, sum_in field positions.
REQ-030 Leading-zero counter SHALL be a sub-module fpaddsub_lzc (25-bit in, 5-bit count, zero flag).

Verification
REQ-031 sum_in=26'h1000000, R=S=0, exp_in=127, sign 0 -> result 0x3F800000 after 3 cycles, no flags.
REQ-032 sum_in=26'h2000000, exp_in=127 -> 0x40000000 (carry normalise).
REQ-033 sum_in=26'h0800000, exp_in=127 -> 0x3F000000 (k=1 cancellation); sum_in=0, R=S=0 -> 0x00000000.
REQ-034 sum_in=26'h1FFFFFF (hidden, fraction all ones, G=1), R=S=0, exp_in=127 -> 0x40000000, flag_inx=1 (RNE tie rounds up on odd lsb).
REQ-035 sum_in=26'h2000000, exp_in=254 -> 0x7F800000, flag_ovf=1; sum_in=26'h0000002, exp_in=5 -> 0x00000000, flag_unf=1.
REQ-036 Stream 5 inputs, out_ready=0 for 6 cycles from cycle 2: in_ready drops once 3 in flight; all 5 results emerge in order, none lost.
